// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-timing helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_RECOVER
    } uart_state_e;

    function automatic int unsigned bit_period(input int unsigned clk_rate,
                                               input int unsigned baud_rate);
        return clk_rate / baud_rate;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_rate,
                                             input int unsigned baud_rate);
        return bit_period(clk_rate, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is parameterised.
module sync_2ff #(
    parameter logic RstVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta <= RstVal;
            r_sync <= RstVal;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, WordSize data bits LSB-first, 1 stop, no parity.
// Centre-samples the synchronised line and holds each word on a valid/ack register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned ClkRate  = 1_152_000,
    parameter int unsigned BaudRate = 115200,
    parameter int unsigned WordSize = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                uart_i,
    output logic [WordSize-1:0] data_o,
    output logic                data_valid_o,
    input  logic                data_ack_i,
    output logic                frame_err_o,
    output logic                overrun_o
);

    localparam int unsigned BitPeriod = bit_period(ClkRate, BaudRate);
    localparam int unsigned HalfBit   = half_bit(ClkRate, BaudRate);
    localparam int unsigned CntW      = $clog2(BitPeriod);
    localparam int unsigned BitW      = $clog2(WordSize + 1);

    if (ClkRate < 4 * BaudRate) begin : g_rate_check
        $error("uart_rx: ClkRate must be at least 4*BaudRate");
    end

    logic                w_rx_s;
    uart_state_e         r_state;
    logic [CntW-1:0]     r_cnt;
    logic [BitW-1:0]     r_bits;
    logic [WordSize-1:0] r_shift;
    logic                r_commit;
    logic [WordSize-1:0] r_data;
    logic                r_valid;
    logic                r_frame_err;
    logic                r_overrun;

    sync_2ff #(
        .RstVal (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (uart_i),
        .q_o   (w_rx_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bits      <= '0;
            r_shift     <= '0;
            r_commit    <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_commit    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                    end
                end
                // Confirm the start bit at its centre; a short low glitch falls back to IDLE.
                ST_START: begin
                    if (r_cnt == CntW'(HalfBit - 1)) begin
                        r_cnt   <= '0;
                        r_bits  <= '0;
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CntW'(BitPeriod - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[WordSize-1:1]};
                        r_bits  <= r_bits + 1'b1;
                        if (r_bits == BitW'(WordSize - 1)) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Leave at stop-bit centre so the next start edge is seen without dead time.
                ST_STOP: begin
                    if (r_cnt == CntW'(BitPeriod - 1)) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_commit <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_RECOVER;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RECOVER: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase

            // An ack on the commit cycle frees the register for the incoming word.
            if (r_commit) begin
                if (!r_valid || data_ack_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (data_ack_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign frame_err_o  = r_frame_err;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: framing, glitch, errors, overrun, reset, loopback.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       uart_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       data_ack_i;
    logic       frame_err_o;
    logic       overrun_o;

    int n_cmp   = 0;
    int n_mis   = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_vrise = 0;
    logic prev_valid = 1'b0;

    uart_rx #(
        .ClkRate  (1_152_000),
        .BaudRate (115200),
        .WordSize (8)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .uart_i       (uart_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ack_i   (data_ack_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse and edge counters sampled mid-cycle.
    always @(negedge clk_i) begin
        if (frame_err_o) n_ferr++;
        if (overrun_o) n_ovr++;
        if (data_valid_o && !prev_valid) n_vrise++;
        prev_valid = data_valid_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sync_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        uart_i = 1'b0;
        repeat (10) sync_edge();
        for (int i = 0; i < 8; i++) begin
            uart_i = d[i];
            repeat (10) sync_edge();
        end
        uart_i = stop;
        repeat (10) sync_edge();
        uart_i = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_i);
            if (data_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
        sync_edge();
    endtask

    task automatic ack_pulse();
        data_ack_i = 1'b1;
        sync_edge();
        data_ack_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_ferr, b_ovr, b_vrise;
        logic [7:0] rnd;

        rst_i      = 1'b1;
        uart_i     = 1'b1;
        data_ack_i = 1'b0;
        repeat (5) sync_edge();
        @(negedge clk_i);
        check("rst_data",  32'(data_o), 32'h0);
        check("rst_valid", 32'(data_valid_o), 32'd0);
        check("rst_ferr",  32'(frame_err_o), 32'd0);
        check("rst_ovr",   32'(overrun_o), 32'd0);
        sync_edge();
        rst_i = 1'b0;
        repeat (5) sync_edge();

        // 0xA5 with ack held low; valid rises 99 clocks after the start edge.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (98) @(posedge clk_i);
                @(negedge clk_i);
                check("a5_lat_pre", 32'(data_valid_o), 32'd0);
                @(posedge clk_i);
                @(negedge clk_i);
                check("a5_lat_post", 32'(data_valid_o), 32'd1);
            end
        join
        @(negedge clk_i);
        check("a5_data", 32'(data_o), 32'hA5);
        repeat (20) sync_edge();
        @(negedge clk_i);
        check("a5_hold", 32'(data_valid_o), 32'd1);
        sync_edge();
        ack_pulse();
        @(negedge clk_i);
        check("a5_ack_valid", 32'(data_valid_o), 32'd0);
        check("a5_ack_data", 32'(data_o), 32'hA5);
        sync_edge();

        // 3-cycle low glitch on idle line.
        b_ferr = n_ferr; b_vrise = n_vrise;
        uart_i = 1'b0;
        repeat (3) sync_edge();
        uart_i = 1'b1;
        repeat (30) sync_edge();
        @(negedge clk_i);
        check("glitch_state", 32'(u_dut.r_state), 32'(ST_IDLE));
        check("glitch_valid", 32'(n_vrise - b_vrise), 32'd0);
        check("glitch_ferr",  32'(n_ferr - b_ferr), 32'd0);
        sync_edge();

        // 0x3C with bad stop, line held low, then 0x55.
        b_ferr = n_ferr; b_vrise = n_vrise; b_ovr = n_ovr;
        send_frame(8'h3C, 1'b0);
        uart_i = 1'b0;
        repeat (40) sync_edge();
        @(negedge clk_i);
        check("brk_state", 32'(u_dut.r_state), 32'(ST_RECOVER));
        check("brk_no_word", 32'(n_vrise - b_vrise), 32'd0);
        sync_edge();
        uart_i = 1'b1;
        repeat (20) sync_edge();
        send_frame(8'h55, 1'b1);
        wait_valid("brk_55_timeout", 20);
        check("brk_data", 32'(data_o), 32'h55);
        check("brk_ferr", 32'(n_ferr - b_ferr), 32'd1);
        check("brk_words", 32'(n_vrise - b_vrise), 32'd1);
        check("brk_ovr", 32'(n_ovr - b_ovr), 32'd0);
        ack_pulse();
        repeat (3) sync_edge();

        // Back-to-back 0x11, 0x22 without ack.
        b_ovr = n_ovr; b_vrise = n_vrise;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2) sync_edge();
        @(negedge clk_i);
        check("ovr_data",  32'(data_o), 32'h11);
        check("ovr_valid", 32'(data_valid_o), 32'd1);
        check("ovr_pulse", 32'(n_ovr - b_ovr), 32'd1);
        check("ovr_rise",  32'(n_vrise - b_vrise), 32'd1);
        sync_edge();
        ack_pulse();
        repeat (3) sync_edge();

        // Ack exactly on the commit cycle of the second word.
        b_ovr = n_ovr; b_vrise = n_vrise;
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (98) @(posedge clk_i);
                #1 data_ack_i = 1'b1;
                @(posedge clk_i);
                #1 data_ack_i = 1'b0;
            end
        join
        repeat (2) sync_edge();
        @(negedge clk_i);
        check("ackc_data",  32'(data_o), 32'h22);
        check("ackc_valid", 32'(data_valid_o), 32'd1);
        check("ackc_ovr",   32'(n_ovr - b_ovr), 32'd0);
        check("ackc_rise",  32'(n_vrise - b_vrise), 32'd1);
        sync_edge();

        // Reset while in DATA with a word still pending, then 0x7E.
        b_ferr = n_ferr; b_ovr = n_ovr;
        uart_i = 1'b0;
        repeat (30) sync_edge();
        @(negedge clk_i);
        check("mid_state", 32'(u_dut.r_state), 32'(ST_DATA));
        sync_edge();
        rst_i  = 1'b1;
        uart_i = 1'b1;
        repeat (3) sync_edge();
        @(negedge clk_i);
        check("mid_rst_data",  32'(data_o), 32'h0);
        check("mid_rst_valid", 32'(data_valid_o), 32'd0);
        check("mid_rst_state", 32'(u_dut.r_state), 32'(ST_IDLE));
        sync_edge();
        rst_i = 1'b0;
        repeat (20) sync_edge();
        send_frame(8'h7E, 1'b1);
        wait_valid("mid_7e_timeout", 20);
        check("mid_7e_data", 32'(data_o), 32'h7E);
        check("mid_no_pulses", 32'((n_ferr - b_ferr) + (n_ovr - b_ovr)), 32'd0);
        ack_pulse();
        repeat (3) sync_edge();

        // Loopback of random words with random ack delay.
        b_ferr = n_ferr; b_ovr = n_ovr;
        for (int k = 0; k < 256; k++) begin
            rnd = 8'($urandom_range(0, 255));
            send_frame(rnd, 1'b1);
            wait_valid("loop_timeout", 20);
            check("loop_data", 32'(data_o), 32'(rnd));
            repeat ($urandom_range(0, 5)) sync_edge();
            ack_pulse();
            repeat ($urandom_range(0, 3)) sync_edge();
        end
        repeat (3) sync_edge();
        check("loop_ferr", 32'(n_ferr - b_ferr), 32'd0);
        check("loop_ovr",  32'(n_ovr - b_ovr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
